// File: rtl/fft_job_arbiter_if.sv
// Handshake bundle between the FFT job arbiter and the two requesters,
// the shared FFT memory mux and the FFT core.
interface fft_job_arbiter_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       req;
    logic             load_done;
    logic             fft_done;
    // "release" is a reserved word, so the owner's read-done strobe is renamed
    logic             release_done;
    logic [1:0]       grant;
    logic             owner;
    logic             start_fft;
    logic             result_valid;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] job_count;

    modport master (
        output req,
        output load_done,
        output fft_done,
        output release_done,
        input  grant,
        input  owner,
        input  start_fft,
        input  result_valid,
        input  busy,
        input  timeout_err,
        input  job_count
    );

    modport slave (
        input  req,
        input  load_done,
        input  fft_done,
        input  release_done,
        output grant,
        output owner,
        output start_fft,
        output result_valid,
        output busy,
        output timeout_err,
        output job_count
    );
endinterface

// File: rtl/fft_job_arbiter.sv
// Round-robin owner arbitration of one shared FFT memory/core between two
// requesters: load, run with timeout, unload, then hand over.
module fft_job_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               clr,
    fft_job_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             owner_q, owner_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] job_count_q, job_count_d;
    logic             timeout_err_q, timeout_err_d;
    logic             winner;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= IDLE;
            grant_q       <= 2'b00;
            owner_q       <= 1'b0;
            last_owner_q  <= 1'b1;
            run_cnt_q     <= '0;
            job_count_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            run_cnt_q     <= run_cnt_d;
            job_count_q   <= job_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Contention goes to whoever did not own the previous job
    always_comb begin
        winner = 1'b0;
        unique case (1'b1)
            (bus.req == 2'b11): winner = ~last_owner_q;
            (bus.req == 2'b10): winner = 1'b1;
            default:            winner = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        run_cnt_d     = run_cnt_q;
        job_count_d   = job_count_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = LOAD;
                    owner_d = winner;
                    grant_d = winner ? 2'b10 : 2'b01;
                end
            end
            LOAD: begin
                if (bus.load_done) begin
                    state_d   = RUN;
                    run_cnt_d = '0;
                end else if (!bus.req[owner_q]) begin
                    state_d      = IDLE;
                    grant_d      = 2'b00;
                    last_owner_d = owner_q;
                end
            end
            RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                // Completion wins over timeout on the final cycle
                if (bus.fft_done && run_cnt_q != '0) begin
                    state_d     = UNLOAD;
                    job_count_d = job_count_q + 1'b1;
                end else if (run_cnt_q == TMO) begin
                    state_d       = IDLE;
                    grant_d       = 2'b00;
                    last_owner_d  = owner_q;
                    timeout_err_d = 1'b1;
                end
            end
            UNLOAD: begin
                if (bus.release_done) begin
                    state_d      = IDLE;
                    grant_d      = 2'b00;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant        = grant_q;
    assign bus.owner        = owner_q;
    assign bus.start_fft    = (state_q == RUN) && (run_cnt_q == '0);
    assign bus.result_valid = (state_q == UNLOAD);
    assign bus.busy         = (state_q != IDLE);
    assign bus.timeout_err  = timeout_err_q;
    assign bus.job_count    = job_count_q;
endmodule

// File: tb/tb_fft_job_arbiter.sv
// Directed bench: vector table for arbitration/handshake plus hand-written
// sequences for long runs, timeout, clear and job counter wrap.
module tb_fft_job_arbiter;
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] req = 2'b00;
    logic       ld  = 1'b0;
    logic       fd  = 1'b0;
    logic       rel = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fft_job_arbiter_if #(.CNT_W(8)) ifa ();
    fft_job_arbiter_if #(.CNT_W(8)) ifb ();

    assign ifa.req          = req;
    assign ifa.load_done    = ld;
    assign ifa.fft_done     = fd;
    assign ifa.release_done = rel;
    assign ifb.req          = req;
    assign ifb.load_done    = ld;
    assign ifb.fft_done     = fd;
    assign ifb.release_done = rel;

    fft_job_arbiter #(.TIMEOUT(255), .CNT_W(8)) dut_a (
        .clk (clk),
        .clr (clr),
        .bus (ifa)
    );

    fft_job_arbiter #(.TIMEOUT(10), .CNT_W(8)) dut_b (
        .clk (clk),
        .clr (clr),
        .bus (ifb)
    );

    typedef struct {
        logic       clr;
        logic [1:0] req;
        logic       ld;
        logic       fd;
        logic       rel;
        logic [1:0] g;
        logic       own;
        logic       st;
        logic       rv;
        logic       bsy;
        logic       te;
        logic [7:0] jc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic c, input logic [1:0] r, input logic l,
                       input logic f, input logic e, input logic [1:0] g,
                       input logic o, input logic s, input logic v,
                       input logic b, input logic t, input logic [7:0] j);
        vec_t x;
        x.clr = c; x.req = r; x.ld = l; x.fd = f; x.rel = e;
        x.g = g; x.own = o; x.st = s; x.rv = v; x.bsy = b; x.te = t; x.jc = j;
        tbl.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] outs_a();
        return {ifa.grant, ifa.owner, ifa.start_fft, ifa.result_valid,
                ifa.busy, ifa.timeout_err, ifa.job_count};
    endfunction

    task automatic do_job(input logic [1:0] r);
        req = r;  tick();
        ld = 1'b1; tick();
        ld = 1'b0; req = 2'b00; tick();
        fd = 1'b1; tick();
        fd = 1'b0; rel = 1'b1; tick();
        rel = 1'b0;
    endtask

    int starts;
    int rvs;

    initial begin
        //   clr req  ld fd rl  grant own st rv bsy te jc
        add(1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add(0, 2'b11, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0);
        add(0, 2'b11, 1, 0, 0, 2'b01, 0, 1, 0, 1, 0, 0);
        add(0, 2'b11, 0, 1, 0, 2'b01, 0, 0, 0, 1, 0, 0);
        add(0, 2'b11, 0, 1, 0, 2'b01, 0, 0, 1, 1, 0, 1);
        add(0, 2'b11, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 1);
        add(0, 2'b11, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 1);
        add(0, 2'b11, 1, 0, 0, 2'b10, 1, 1, 0, 1, 0, 1);
        add(0, 2'b11, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 1);
        add(0, 2'b11, 0, 1, 0, 2'b10, 1, 0, 1, 1, 0, 2);
        add(0, 2'b11, 0, 0, 0, 2'b10, 1, 0, 1, 1, 0, 2);
        add(0, 2'b11, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0, 2);
        add(0, 2'b11, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 2);
        add(0, 2'b11, 1, 0, 0, 2'b01, 0, 1, 0, 1, 0, 2);
        add(0, 2'b11, 0, 1, 0, 2'b01, 0, 0, 0, 1, 0, 2);
        add(0, 2'b11, 0, 1, 0, 2'b01, 0, 0, 1, 1, 0, 3);
        add(0, 2'b00, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3);
        add(0, 2'b10, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 3);
        add(0, 2'b01, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 3);
        add(0, 2'b11, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 3);
        add(0, 2'b10, 1, 0, 0, 2'b01, 0, 1, 0, 1, 0, 3);
        add(0, 2'b00, 0, 0, 1, 2'b01, 0, 0, 0, 1, 0, 3);
        add(0, 2'b00, 0, 1, 0, 2'b01, 0, 0, 1, 1, 0, 4);
        add(0, 2'b00, 1, 0, 0, 2'b01, 0, 0, 1, 1, 0, 4);
        add(0, 2'b00, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 4);
        add(0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 4);
        add(0, 2'b01, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 4);
        add(0, 2'b01, 0, 1, 0, 2'b01, 0, 0, 0, 1, 0, 4);
        add(1, 2'b01, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

        tick();
        foreach (tbl[i]) begin
            clr = tbl[i].clr; req = tbl[i].req; ld = tbl[i].ld;
            fd = tbl[i].fd;   rel = tbl[i].rel;
            tick();
            check($sformatf("vec%0d", i), {16'h0, outs_a()},
                  {16'h0, tbl[i].g, tbl[i].own, tbl[i].st, tbl[i].rv,
                   tbl[i].bsy, tbl[i].te, tbl[i].jc});
        end
        clr = 1'b0; req = 2'b00; ld = 1'b0; fd = 1'b0; rel = 1'b0;

        // Single job, load_done three cycles in, fft_done at counter 120
        clr = 1'b1; tick(); clr = 1'b0;
        req = 2'b01; tick();
        check("a_grant_load", ifa.grant, 2'b01);
        tick(); tick();
        ld = 1'b1; tick(); ld = 1'b0;
        starts = 0; rvs = 0;
        starts += ifa.start_fft;
        for (int i = 0; i < 120; i++) begin
            tick();
            starts += ifa.start_fft;
        end
        check("a_busy_cnt120", ifa.busy, 1'b1);
        check("a_grant_run", ifa.grant, 2'b01);
        fd = 1'b1; tick(); fd = 1'b0;
        rvs += ifa.result_valid;
        check("a_job_count1", ifa.job_count, 8'd1);
        tick(); rvs += ifa.result_valid;
        rel = 1'b1; req = 2'b00; tick(); rel = 1'b0;
        rvs += ifa.result_valid;
        check("a_start_pulses", starts, 1);
        check("a_rv_cycles", rvs, 2);
        check("a_busy_after_rel", ifa.busy, 1'b0);
        check("a_grant_after_rel", ifa.grant, 2'b00);

        // Clear during RUN with a completion on the same edge
        req = 2'b01; tick();
        ld = 1'b1; tick(); ld = 1'b0;
        tick();
        fd = 1'b1; clr = 1'b1; tick(); fd = 1'b0; clr = 1'b0; req = 2'b00;
        check("a_clr_run_outs", {16'h0, outs_a()}, 32'h0);

        // First job after clear with both requesting goes to requester 0
        req = 2'b11; tick();
        check("a_first_after_clr", {ifa.grant, ifa.owner}, 3'b010);
        req = 2'b00; tick();
        check("a_abort_idle", ifa.busy, 1'b0);

        // Clear during UNLOAD
        req = 2'b01; tick();
        ld = 1'b1; tick(); ld = 1'b0; req = 2'b00;
        tick();
        fd = 1'b1; tick(); fd = 1'b0;
        check("a_unload_rv", ifa.result_valid, 1'b1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("a_clr_unload_outs", {16'h0, outs_a()}, 32'h0);

        // Job counter wraps after 256 completions
        for (int j = 0; j < 255; j++) do_job(2'b01);
        check("a_jc_255", ifa.job_count, 8'd255);
        do_job(2'b01);
        check("a_jc_wrap", ifa.job_count, 8'd0);

        // Timeout on the TIMEOUT=10 instance
        clr = 1'b1; tick(); clr = 1'b0;
        req = 2'b01; tick();
        ld = 1'b1; tick(); ld = 1'b0; req = 2'b00;
        check("b_start_cnt0", ifb.start_fft, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        check("b_busy_cnt10", ifb.busy, 1'b1);
        check("b_no_start_cnt10", ifb.start_fft, 1'b0);
        tick();
        check("b_tmo_idle", {ifb.busy, ifb.grant}, 3'b000);
        check("b_tmo_err", ifb.timeout_err, 1'b1);
        check("b_tmo_jc", ifb.job_count, 8'd0);
        do_job(2'b01);
        check("b_next_job_jc", ifb.job_count, 8'd1);
        check("b_err_sticky", ifb.timeout_err, 1'b1);

        // Completion exactly at counter == TIMEOUT
        req = 2'b01; tick();
        ld = 1'b1; tick(); ld = 1'b0; req = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        fd = 1'b1; tick(); fd = 1'b0;
        check("b_done_at_tmo_rv", ifb.result_valid, 1'b1);
        check("b_done_at_tmo_jc", ifb.job_count, 8'd2);
        rel = 1'b1; tick(); rel = 1'b0;
        check("b_done_at_tmo_idle", ifb.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_job_arbiter.md
FFT_JOB_ARBITER -- requirements
Module: fft_job_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 255, max RUN cycles after start_fft pulse before abort; legal range 2..255.
REQ-002 Parameter: CNT_W, 8, width of RUN cycle counter and job counter.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: clr  input  1  reset, synchronous, active-high.
REQ-005 Port: req  input  2  req[i]=1: requester i wants one 32-point transform.
REQ-006 Port: load_done  input  1  owner has finished writing 32 samples into FFT memory.
REQ-007 Port: fft_done  input  1  completion indication from FFT core.
REQ-008 Port: release  input  1  owner has finished reading results.
REQ-009 Port: grant  output  2  one-hot ownership of shared FFT memory/core; 2'b00 when unowned.
REQ-010 Port: owner  output  1  index of current/last owner; drives memory port mux.
REQ-011 Port: start_fft  output  1  one-cycle start pulse to FFT core.
REQ-012 Port: result_valid  output  1  results in FFT memory readable by owner.
REQ-013 Port: busy  output  1  high in any state other than IDLE.
REQ-014 Port: timeout_err  output  1  sticky: a RUN phase hit TIMEOUT.
REQ-015 Port: job_count  output  CNT_W  number of completed transforms, modulo 2^CNT_W.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, RUN, UNLOAD; all outputs registered or decoded from registered state only.
REQ-017 IDLE: any req[i]=1 sampled -> LOAD next cycle; owner loaded; grant[owner]=1 from that cycle.
REQ-018 Arbitration SHALL be round-robin: both req high -> requester != last_owner wins; single req -> that requester wins.
REQ-019 last_owner SHALL update to owner on every exit to IDLE (release, abort, timeout).
REQ-020 LOAD: load_done=1 -> RUN next cycle; req[owner]=0 (load_done=0) -> IDLE next cycle (abort, no start_fft); load_done=1 has priority over req drop in the same cycle.
REQ-021 RUN: run counter cleared on entry, +1 per RUN cycle; start_fft=1 only in first RUN cycle (counter=0).
REQ-022 fft_done SHALL be ignored outside RUN and in the first RUN cycle.
REQ-023 RUN, counter>=1, fft_done=1 -> UNLOAD next cycle; job_count +1 (wraps 2^CNT_W-1 -> 0).
REQ-024 RUN, counter==TIMEOUT, fft_done=0 -> IDLE next cycle; timeout_err set; grant cleared; job_count unchanged.
REQ-025 fft_done=1 at counter==TIMEOUT SHALL count as completion, not timeout.
REQ-026 UNLOAD: result_valid=1; release=1 -> IDLE next cycle; result_valid, grant cleared same cycle.
REQ-027 release, load_done SHALL be ignored outside UNLOAD and LOAD respectively; req changes ignored outside IDLE/LOAD.
REQ-028 grant SHALL remain constant and one-hot throughout LOAD, RUN, UNLOAD.
REQ-029 Minimum IDLE dwell SHALL be one cycle between jobs (release at edge k, IDLE after k, next grant after k+1).

Reset
REQ-030 clr=1 at an edge SHALL force, regardless of state: IDLE, grant=00, owner=0, last_owner=1, start_fft=0, result_valid=0, busy=0, timeout_err=0, job_count=0, run counter=0.
REQ-031 clr mid-RUN SHALL suppress any pending completion; no job_count increment; clr has priority over all inputs.
REQ-032 First job after reset with req=11 SHALL go to requester 0.

Verification
REQ-033 Reset then req=01, load_done after 3 cycles, fft_done at counter=120, release 2 cycles later -> grant=01, one start_fft pulse, result_valid 2 cycles, job_count=1, busy low after release.
REQ-034 req=11 held for three jobs -> grant sequence 01,10,01; owner 0,1,0; job_count=3.
REQ-035 TIMEOUT=10, no fft_done -> start_fft at counter 0, IDLE after counter=10 edge, timeout_err=1 sticky, job_count=0; next job completes normally with timeout_err still 1.
REQ-036 LOAD with req[owner] dropped before load_done -> IDLE, no start_fft, last_owner updated, other requester wins next.
REQ-037 fft_done pulses in IDLE, LOAD and first RUN cycle -> no state change, job_count unchanged; fft_done at counter=TIMEOUT -> UNLOAD.
REQ-038 clr asserted in RUN and in UNLOAD -> all outputs at reset values next cycle; job_count=255 plus one completion -> 0.
